set_region_counter: RTL

//  Parametrised successor of the SET circle-coverage counter. Counts lattice points of a

---
 rtl/set_region_pkg.sv | 22 ++
 rtl/set_region_member.sv | 37 +++
 rtl/set_region_counter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/set_region_pkg.sv
// Shared types and defaults for the region counter.
// Optional build macro used by the top: SET_REGION_PIPE_EN.
package set_region_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned NUM_CIRCLES_DEF = 3;
  localparam int unsigned GRID_W_DEF      = 8;
  localparam int unsigned COORD_W_DEF     = 4;
  localparam int unsigned R_W_DEF         = 4;

  // Counter must hold GRID_W^2 itself (every point a hit).
  function automatic int unsigned cnt_width(input int unsigned grid_w);
    return $clog2(grid_w * grid_w + 1);
  endfunction

endpackage

// File: rtl/set_region_member.sv
// Combinational circle membership test with exact squared distances.
module set_region_member #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned R_W     = 4,
  parameter int unsigned XY_W    = 4
) (
  input  logic [XY_W-1:0]    x_i,
  input  logic [XY_W-1:0]    y_i,
  input  logic [COORD_W-1:0] cx_i,
  input  logic [COORD_W-1:0] cy_i,
  input  logic [R_W-1:0]     r_i,
  output logic               in_circle_o
);

  localparam int unsigned DW  = ((XY_W > COORD_W) ? XY_W : COORD_W) + 1;
  localparam int unsigned SW  = 2 * DW + 1;
  localparam int unsigned RW2 = 2 * R_W;
  localparam int unsigned CW  = (SW > RW2) ? SW : RW2;

  logic [DW-1:0] xe, ye, cxe, cye, dx, dy;
  logic [CW-1:0] dx2, dy2, dsum, r2;

  always_comb begin
    xe  = DW'(x_i);
    ye  = DW'(y_i);
    cxe = DW'(cx_i);
    cye = DW'(cy_i);
    dx  = (xe >= cxe) ? (xe - cxe) : (cxe - xe);
    dy  = (ye >= cye) ? (ye - cye) : (cye - ye);
    dx2 = CW'(dx) * CW'(dx);
    dy2 = CW'(dy) * CW'(dy);
    dsum = dx2 + dy2;
    r2  = CW'(r_i) * CW'(r_i);
    in_circle_o = (dsum <= r2);
  end

endmodule

// File: rtl/set_region_counter.sv
// Scans a GRID_W x GRID_W lattice and counts points selected by a truth table over
// circle membership. Define SET_REGION_PIPE_EN to register the hit bit before acc.
module set_region_counter
  import set_region_pkg::*;
#(
  parameter int unsigned NUM_CIRCLES = NUM_CIRCLES_DEF,
  parameter int unsigned GRID_W      = GRID_W_DEF,
  parameter int unsigned COORD_W     = COORD_W_DEF,
  parameter int unsigned R_W         = R_W_DEF,
  parameter int unsigned CNT_W       = cnt_width(GRID_W)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [NUM_CIRCLES*2*COORD_W-1:0] central,
  input  logic [NUM_CIRCLES*R_W-1:0]       radius,
  input  logic [2**NUM_CIRCLES-1:0]        func,
  output logic                             busy,
  output logic                             valid,
  output logic [CNT_W-1:0]                 candidate
);

  localparam int unsigned XY_W = $clog2(GRID_W + 1);
  localparam logic [XY_W-1:0] XMAX = XY_W'(GRID_W);
  localparam logic [XY_W-1:0] XONE = XY_W'(1);

  state_t                           state_q, state_d;
  logic [XY_W-1:0]                  x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]                 acc_q, acc_d, cand_q, cand_d;
  logic [NUM_CIRCLES*2*COORD_W-1:0] central_q, central_d;
  logic [NUM_CIRCLES*R_W-1:0]       radius_q, radius_d;
  logic [2**NUM_CIRCLES-1:0]        func_q, func_d;
  logic [NUM_CIRCLES-1:0]           in_vec;
  logic                             hit;
  logic [CNT_W-1:0]                 addend;

  for (genvar i = 0; i < NUM_CIRCLES; i++) begin : g_circle
    localparam int unsigned CO = (NUM_CIRCLES - 1 - i) * 2 * COORD_W;
    localparam int unsigned RO = (NUM_CIRCLES - 1 - i) * R_W;
    set_region_member #(
      .COORD_W(COORD_W),
      .R_W    (R_W),
      .XY_W   (XY_W)
    ) u_member (
      .x_i        (x_q),
      .y_i        (y_q),
      .cx_i       (central_q[CO+COORD_W +: COORD_W]),
      .cy_i       (central_q[CO +: COORD_W]),
      .r_i        (radius_q[RO +: R_W]),
      .in_circle_o(in_vec[i])
    );
  end

  assign hit = func_q[in_vec];

`ifdef SET_REGION_PIPE_EN
  logic hit_q, hit_d;
  // hit_q lags the scan by one point; it is zero on the first SCAN cycle.
  assign hit_d  = (state_q == SCAN) ? hit : 1'b0;
  assign addend = CNT_W'(hit_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_q <= 1'b0;
    else     hit_q <= hit_d;
  end
`else
  assign addend = CNT_W'(hit);
`endif

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    cand_d    = cand_q;
    central_d = central_q;
    radius_d  = radius_q;
    func_d    = func_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = SCAN;
          central_d = central;
          radius_d  = radius;
          func_d    = func;
          acc_d     = '0;
          x_d       = XONE;
          y_d       = XONE;
        end
      end
      SCAN: begin
        acc_d = acc_q + addend;
        if (x_q == XMAX) begin
          x_d = XONE;
          if (y_q == XMAX) begin
            y_d = XONE;
`ifdef SET_REGION_PIPE_EN
            state_d = FLUSH;
`else
            state_d = DONE;
            cand_d  = acc_q + addend;
`endif
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      FLUSH: begin
`ifdef SET_REGION_PIPE_EN
        cand_d  = acc_q + addend;
        state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= XONE;
      y_q       <= XONE;
      acc_q     <= '0;
      cand_q    <= '0;
      central_q <= '0;
      radius_q  <= '0;
      func_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      cand_q    <= cand_d;
      central_q <= central_d;
      radius_q  <= radius_d;
      func_q    <= func_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign valid     = (state_q == DONE);
  assign candidate = cand_q;

endmodule
